// File: rtl/decode_stage.sv
// RV32I decode stage: decodes each accepted instruction into a two-entry elastic buffer; 1-cycle latency, in_ready from state only.
// Optional feature: define DECODE_STAGE_M_EXT_EN to accept OP instructions with funct7=0000001 (M extension).
module decode_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_immed,
  output logic            out_illegal,
  output logic            out_writes_rd
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [2:0]      fmt;
    logic [XLEN-1:0] immed;
    logic            illegal;
    logic            writes_rd;
  } entry_t;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t state;
  entry_t head, skid, dec;

  logic [6:0]      opc, f7;
  logic [2:0]      f3, fmt;
  logic            ill, m_ok;
  logic [XLEN-1:0] imm;

  assign opc = in_inst[6:0];
  assign f3  = in_inst[14:12];
  assign f7  = in_inst[31:25];

`ifdef DECODE_STAGE_M_EXT_EN
  assign m_ok = (f7 == 7'b0000001);
`else
  assign m_ok = 1'b0;
`endif

  always_comb begin
    fmt = FMT_R;
    ill = 1'b0;
    unique case (opc)
      OPC_LOAD: begin
        fmt = FMT_I;
        ill = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OPC_OP_IMM: begin
        fmt = FMT_I;
        if (f3 == 3'b001)
          ill = (f7 != 7'b0000000);
        else if (f3 == 3'b101)
          ill = !((f7 == 7'b0000000) || (f7 == 7'b0100000));
      end
      OPC_JALR: begin
        fmt = FMT_I;
        ill = (f3 != 3'b000);
      end
      OPC_MISC_MEM, OPC_SYSTEM: fmt = FMT_I;
      OPC_STORE: begin
        fmt = FMT_S;
        ill = (f3 > 3'b010);
      end
      OPC_OP: begin
        fmt = FMT_R;
        ill = !((f7 == 7'b0000000) ||
                ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))) ||
                m_ok);
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        ill = (f3 == 3'b010) || (f3 == 3'b011);
      end
      OPC_LUI, OPC_AUIPC: fmt = FMT_U;
      OPC_JAL:            fmt = FMT_J;
      default:            ill = 1'b1;
    endcase
    if (in_inst[1:0] != 2'b11)
      ill = 1'b1;

    unique case (fmt)
      FMT_I:   imm = XLEN'($signed(in_inst[31:20]));
      FMT_S:   imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
      FMT_B:   imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
      FMT_U:   imm = XLEN'($signed({in_inst[31:12], 12'b0}));
      FMT_J:   imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
      default: imm = '0;
    endcase

    // Illegal words keep their raw fields but carry no format or immediate.
    if (ill) begin
      fmt = FMT_R;
      imm = '0;
    end

    dec           = '0;
    dec.pc        = in_pc;
    dec.opcode    = opc;
    dec.rs1       = in_inst[19:15];
    dec.rs2       = in_inst[24:20];
    dec.rd        = in_inst[11:7];
    dec.funct3    = f3;
    dec.funct7    = f7;
    dec.fmt       = fmt;
    dec.immed     = imm;
    dec.illegal   = ill;
    dec.writes_rd = !ill && (fmt != FMT_S) && (fmt != FMT_B) && (in_inst[11:7] != 5'd0);
  end

  logic accept, pop;
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      head  <= '0;
      skid  <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      unique case (state)
        EMPTY: if (accept) begin
          head  <= dec;
          state <= ONE;
        end
        ONE: begin
          if (accept && pop) begin
            head <= dec;
          end else if (accept) begin
            skid  <= dec;
            state <= TWO;
          end else if (pop) begin
            state <= EMPTY;
          end
        end
        TWO: if (pop) begin
          head  <= skid;
          state <= ONE;
        end
        default: state <= EMPTY;
      endcase
    end
  end

  assign out_pc        = head.pc;
  assign out_opcode    = head.opcode;
  assign out_rs1       = head.rs1;
  assign out_rs2       = head.rs2;
  assign out_rd        = head.rd;
  assign out_funct3    = head.funct3;
  assign out_funct7    = head.funct7;
  assign out_fmt       = head.fmt;
  assign out_immed     = head.immed;
  assign out_illegal   = head.illegal;
  assign out_writes_rd = head.writes_rd;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: directed instruction words with hand-computed decode results.
module tb_decode_stage;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]     in_inst;
  logic [XLEN-1:0] in_pc, out_pc, out_immed;
  logic [6:0]      out_opcode, out_funct7;
  logic [4:0]      out_rs1, out_rs2, out_rd;
  logic [2:0]      out_funct3, out_fmt;
  logic            out_illegal, out_writes_rd;

  decode_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_fmt(out_fmt),
    .out_immed(out_immed), .out_illegal(out_illegal), .out_writes_rd(out_writes_rd)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic        ill, wr;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e, mon_got;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] pc = 32'h1000;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] p, input logic [31:0] inst, input logic [2:0] fmt,
                              input logic [31:0] imm, input logic ill, input logic wr);
    exp_t e;
    e.pc = p; e.opcode = inst[6:0]; e.rs1 = inst[19:15]; e.rs2 = inst[24:20];
    e.rd = inst[11:7]; e.f3 = inst[14:12]; e.f7 = inst[31:25];
    e.fmt = fmt; e.imm = imm; e.ill = ill; e.wr = wr;
    return e;
  endfunction

  // Monitor: every handshake on the output side must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      mon_got = {out_pc, out_opcode, out_rs1, out_rs2, out_rd, out_funct3, out_funct7,
                 out_fmt, out_immed, out_illegal, out_writes_rd};
      if (sb.size() == 0) begin
        chk("unexpected_output", 128'(mon_got), 128'(0));
      end else begin
        mon_e = sb.pop_front();
        chk("out_bundle", 128'(mon_got), 128'(mon_e));
      end
    end
  end

  task automatic send(input logic [31:0] inst, input logic [2:0] fmt, input logic [31:0] imm,
                      input logic ill, input logic wr);
    bit acc = 0;
    int n = 0;
    in_inst  = inst;
    in_pc    = pc;
    in_valid = 1'b1;
    while (!acc && n < 50) begin
      acc = in_ready;
      if (acc) sb.push_back(mk(pc, inst, fmt, imm, ill, wr));
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
    pc += 4;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", sb.size(), 0);
  endtask

  task automatic flush_with_input(input logic [31:0] inst);
    in_inst  = inst;
    in_pc    = 32'hDEAD0000;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(posedge clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
  endtask

  logic [31:0] pc_a;
  logic        mul_ill, mul_wr;

  initial begin
`ifdef DECODE_STAGE_M_EXT_EN
    mul_ill = 1'b0; mul_wr = 1'b1;
`else
    mul_ill = 1'b1; mul_wr = 1'b0;
`endif
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_immed", out_immed, 0);
    chk("rst_fields", {out_opcode, out_rs1, out_rs2, out_rd, out_funct3, out_funct7, out_fmt,
                       out_illegal, out_writes_rd}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Streaming at full rate.
    out_ready = 1'b1;
    send(32'hFFC12283, 3'd1, 32'hFFFFFFFC, 0, 1);               // lw x5,-4(x2)
    chk("latency_out_valid", out_valid, 1);
    chk("latency_lw_immed", out_immed, 32'hFFFFFFFC);
    send(32'h00512423, 3'd2, 32'h00000008, 0, 0);               // sw x5,8(x2)
    send(32'h80000537, 3'd4, 32'h80000000, 0, 1);               // lui x10,0x80000
    send(32'h023100B3, 3'd0, 32'h00000000, mul_ill, mul_wr);    // mul x1,x2,x3
    send(32'h00000000, 3'd0, 32'h00000000, 1, 0);               // all zeros
    send(32'h00208863, 3'd3, 32'h00000010, 0, 0);               // beq x1,x2,16
    send(32'hFFDFF0EF, 3'd5, 32'hFFFFFFFC, 0, 1);               // jal x1,-4
    send(32'h402081B3, 3'd0, 32'h00000000, 0, 1);               // sub x3,x1,x2
    send(32'h402091B3, 3'd0, 32'h00000000, 1, 0);               // OP funct7=0100000 funct3=001
    send(32'h00000013, 3'd1, 32'h00000000, 0, 0);               // addi x0,x0,0
    send(32'h40315093, 3'd1, 32'h00000403, 0, 1);               // srai x1,x2,3
    send(32'h00013283, 3'd0, 32'h00000000, 1, 0);               // LOAD funct3=011
    send(32'h12345097, 3'd4, 32'h12345000, 0, 1);               // auipc x1,0x12345
    send(32'h00000012, 3'd0, 32'h00000000, 1, 0);               // inst[1:0]=10
    drain();

    // Backpressure: A and B fill the buffer, C waits.
    out_ready = 1'b0;
    pc_a = pc;
    send(32'h00108093, 3'd1, 32'h00000001, 0, 1);               // addi x1,x1,1
    send(32'h00208113, 3'd1, 32'h00000002, 0, 1);               // addi x2,x1,2
    chk("full_in_ready", in_ready, 0);
    chk("full_head_pc", out_pc, pc_a);
    in_inst = 32'h00310193; in_pc = pc; in_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("stall_in_ready", in_ready, 0);
    chk("stall_head_pc", out_pc, pc_a);
    chk("stall_head_immed", out_immed, 32'h00000001);
    out_ready = 1'b1;
    send(32'h00310193, 3'd1, 32'h00000003, 0, 1);               // addi x3,x2,3
    drain();

    // Flush with one entry buffered and an acceptable input presented.
    out_ready = 1'b0;
    send(32'h00400213, 3'd1, 32'h00000004, 0, 1);               // addi x4,x0,4
    flush_with_input(32'h00500293);
    // Flush with the buffer full.
    send(32'h00400213, 3'd1, 32'h00000004, 0, 1);
    send(32'h00600313, 3'd1, 32'h00000006, 0, 1);               // addi x6,x0,6
    flush_with_input(32'h00500293);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("post_flush_idle", out_valid, 0);
    send(32'h00700393, 3'd1, 32'h00000007, 0, 1);               // addi x7,x0,7
    drain();

    // Asynchronous reset between edges clears both entries.
    out_ready = 1'b0;
    send(32'h00108093, 3'd1, 32'h00000001, 0, 1);
    send(32'h00208113, 3'd1, 32'h00000002, 0, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_in_ready", in_ready, 1);
    chk("async_rst_out_pc", out_pc, 0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
